cpu_image_loader: RTL and testbench

//  Upstream host-side loader for the single-cycle MNIST CPU. Accepts a byte stream (valid/ready),

---
 rtl/cpu_image_loader_pkg.sv | 31 +++
 rtl/cpu_image_loader_byte_word_assembler.sv | 44 ++++
 rtl/cpu_image_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_cpu_image_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_image_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Purpose  : Shared command codes, FSM state encoding and per-word byte
//            counts for the CPU image loader.
// Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

  // Host command bytes recognised in IDLE
  localparam logic [7:0] CMD_I = 8'h49;  // 'I' load instruction memory
  localparam logic [7:0] CMD_D = 8'h44;  // 'D' load data memory
  localparam logic [7:0] CMD_G = 8'h47;  // 'G' reset CPU and run

  // Bytes per memory word
  localparam int IBYTES = 2;
  localparam int DBYTES = 8;

  // Loader FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_LOAD = 3'd1,
    D_HDR  = 3'd2,
    D_LOAD = 3'd3,
    GO_RST = 3'd4,
    RUN    = 3'd5,
    REPORT = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_image_loader_byte_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : byte_word_assembler
// Purpose  : Shifts accepted bytes MSB-first into a word and flags the byte
//            that completes a word of nbytes_i bytes. word_o already includes
//            the byte currently presented, so the completing byte can be
//            captured on the same edge it is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module byte_word_assembler #(
  parameter int DDATA_W = 64,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               byte_en_i,
  input  logic [7:0]         byte_i,
  input  logic [CNT_W-1:0]   nbytes_i,
  output logic [DDATA_W-1:0] word_o,
  output logic               word_done_o
);

  logic [DDATA_W-9:0] shift_q;
  logic [CNT_W-1:0]   cnt_q;

  assign word_o      = {shift_q, byte_i};
  assign word_done_o = byte_en_i && (cnt_q == (nbytes_i - CNT_W'(1)));

  // Byte shift register and position counter; counter restarts per word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr_i) begin
      cnt_q   <= '0;
    end else if (byte_en_i) begin
      shift_q <= word_o[DDATA_W-9:0];
      cnt_q   <= word_done_o ? '0 : (cnt_q + CNT_W'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_image_loader.sv
`default_nettype none
// ============================================================================
// Module   : cpu_image_loader
// Purpose  : Host byte-stream loader for the single-cycle MNIST CPU. Writes
//            instruction and data memories, pulses CPU reset, waits for
//            flag_done and returns the captured Out_R label.
// Options  : LOADER_TIMEOUT_EN - adds a RUN watchdog of TO_CYC cycles that
//            reports 16'hFFFF and raises err when cpu_done never arrives.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_image_loader
  import loader_pkg::*;
#(
  parameter int IADDR_W = 3,
  parameter int IDATA_W = 16,
  parameter int DADDR_W = 7,
  parameter int DDATA_W = 64,
  parameter int RST_CYC = 2,
  parameter int TO_CYC  = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  output logic               ex_iwe,
  output logic [IADDR_W-1:0] ex_iaddr,
  output logic [IDATA_W-1:0] ex_idata,
  output logic               ex_dwe,
  output logic [DADDR_W-1:0] ex_daddr,
  output logic [DDATA_W-1:0] ex_ddata,
  output logic               cpu_rst_n,
  input  logic [15:0]        cpu_out_r,
  input  logic               cpu_done,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [15:0]        res_data,
  output logic               busy,
  output logic               err
);

  localparam int CNT_W = 4;
  localparam int RST_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  // Elaboration guard against meaningless cycle counts
  if ((RST_CYC < 1) || (TO_CYC < 1)) begin : g_bad_params
    $error("cpu_image_loader: RST_CYC and TO_CYC must be >= 1");
  end

  state_t             state_q;
  logic               in_ready_q;
  logic               ex_iwe_q;
  logic [IADDR_W-1:0] ex_iaddr_q;
  logic [IDATA_W-1:0] ex_idata_q;
  logic               ex_dwe_q;
  logic [DADDR_W-1:0] ex_daddr_q;
  logic [DDATA_W-1:0] ex_ddata_q;
  logic               cpu_rst_n_q;
  logic               res_valid_q;
  logic [15:0]        res_data_q;
  logic               err_q;
  logic [15:0]        shadow_q;
  logic [IADDR_W-1:0] iaddr_cnt_q;
  logic [DADDR_W-1:0] daddr_cnt_q;
  logic [7:0]         dcount_q;
  logic               hdr_second_q;
  logic [RST_W-1:0]   rst_cnt_q;
`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0]    to_cnt_q;
`endif

  logic               w_accept;
  logic               w_loading;
  logic [CNT_W-1:0]   w_nbytes;
  logic [DDATA_W-1:0] w_word;
  logic               w_word_done;

  assign w_accept  = in_valid && in_ready_q;
  assign w_loading = (state_q == I_LOAD) || (state_q == D_LOAD);
  assign w_nbytes  = (state_q == D_LOAD) ? CNT_W'(DBYTES) : CNT_W'(IBYTES);

  byte_word_assembler #(
    .DDATA_W (DDATA_W),
    .CNT_W   (CNT_W)
  ) u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (!w_loading),
    .byte_en_i   (w_accept && w_loading),
    .byte_i      (in_data),
    .nbytes_i    (w_nbytes),
    .word_o      (w_word),
    .word_done_o (w_word_done)
  );

  // Loader FSM: command decode, addressing, write strobes and CPU control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      ex_iwe_q     <= 1'b0;
      ex_iaddr_q   <= '0;
      ex_idata_q   <= '0;
      ex_dwe_q     <= 1'b0;
      ex_daddr_q   <= '0;
      ex_ddata_q   <= '0;
      cpu_rst_n_q  <= 1'b1;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      err_q        <= 1'b0;
      shadow_q     <= '0;
      iaddr_cnt_q  <= '0;
      daddr_cnt_q  <= '0;
      dcount_q     <= '0;
      hdr_second_q <= 1'b0;
      rst_cnt_q    <= '0;
`ifdef LOADER_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      ex_iwe_q <= 1'b0;
      ex_dwe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            case (in_data)
              CMD_I: begin
                state_q     <= I_LOAD;
                err_q       <= 1'b0;
                iaddr_cnt_q <= '0;
              end
              CMD_D: begin
                state_q      <= D_HDR;
                err_q        <= 1'b0;
                hdr_second_q <= 1'b0;
              end
              CMD_G: begin
                state_q     <= GO_RST;
                err_q       <= 1'b0;
                in_ready_q  <= 1'b0;
                cpu_rst_n_q <= 1'b0;
                rst_cnt_q   <= '0;
                shadow_q    <= '0;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        I_LOAD: begin
          if (w_word_done) begin
            ex_iwe_q    <= 1'b1;
            ex_iaddr_q  <= iaddr_cnt_q;
            ex_idata_q  <= w_word[IDATA_W-1:0];
            iaddr_cnt_q <= iaddr_cnt_q + IADDR_W'(1);
            if (iaddr_cnt_q == {IADDR_W{1'b1}}) state_q <= IDLE;
          end
        end
        D_HDR: begin
          if (w_accept) begin
            if (!hdr_second_q) begin
              daddr_cnt_q  <= in_data[DADDR_W-1:0];
              hdr_second_q <= 1'b1;
            end else if (in_data == 8'h00) begin
              state_q <= IDLE;
            end else begin
              dcount_q <= in_data;
              state_q  <= D_LOAD;
            end
          end
        end
        D_LOAD: begin
          if (w_word_done) begin
            ex_dwe_q    <= 1'b1;
            ex_daddr_q  <= daddr_cnt_q;
            ex_ddata_q  <= w_word;
            daddr_cnt_q <= daddr_cnt_q + DADDR_W'(1);
            dcount_q    <= dcount_q - 8'd1;
            if (dcount_q == 8'd1) state_q <= IDLE;
          end
        end
        GO_RST: begin
          if (rst_cnt_q == RST_W'(RST_CYC - 1)) begin
            cpu_rst_n_q <= 1'b1;
            state_q     <= RUN;
`ifdef LOADER_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
          end else begin
            rst_cnt_q <= rst_cnt_q + RST_W'(1);
          end
        end
        RUN: begin
          if (cpu_done) begin
            // Out_R present on the done cycle wins over the shadow copy
            state_q     <= REPORT;
            res_valid_q <= 1'b1;
            res_data_q  <= (cpu_out_r != 16'h0000) ? cpu_out_r : shadow_q;
          end else begin
            if (cpu_out_r != 16'h0000) shadow_q <= cpu_out_r;
`ifdef LOADER_TIMEOUT_EN
            if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
              state_q     <= REPORT;
              err_q       <= 1'b1;
              res_valid_q <= 1'b1;
              res_data_q  <= 16'hFFFF;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
`endif
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign ex_iwe    = ex_iwe_q;
  assign ex_iaddr  = ex_iaddr_q;
  assign ex_idata  = ex_idata_q;
  assign ex_dwe    = ex_dwe_q;
  assign ex_daddr  = ex_daddr_q;
  assign ex_ddata  = ex_ddata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cpu_image_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_image_loader
// Purpose  : Directed, table-driven bench for cpu_image_loader. Expected
//            memory writes live in a table; CPU behaviour is driven directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_image_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        ex_iwe;
  logic [2:0]  ex_iaddr;
  logic [15:0] ex_idata;
  logic        ex_dwe;
  logic [6:0]  ex_daddr;
  logic [63:0] ex_ddata;
  logic        cpu_rst_n;
  logic [15:0] cpu_out_r;
  logic        cpu_done;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        busy;
  logic        err;

  cpu_image_loader #(
    .IADDR_W (3),
    .IDATA_W (16),
    .DADDR_W (7),
    .DDATA_W (64),
    .RST_CYC (2),
    .TO_CYC  (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ex_iwe    (ex_iwe),
    .ex_iaddr  (ex_iaddr),
    .ex_idata  (ex_idata),
    .ex_dwe    (ex_dwe),
    .ex_daddr  (ex_daddr),
    .ex_ddata  (ex_ddata),
    .cpu_rst_n (cpu_rst_n),
    .cpu_out_r (cpu_out_r),
    .cpu_done  (cpu_done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_i;
    logic [6:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_tbl [12];
  wr_t log_q [$];
  bit  both_hi = 1'b0;
  int  checks  = 0;
  int  errors  = 0;

  // Record every write strobe mid-cycle
  always @(negedge clk) begin
    if (ex_iwe && ex_dwe) both_hi = 1'b1;
    if (ex_iwe) log_q.push_back('{1'b1, {4'b0, ex_iaddr}, {48'b0, ex_idata}});
    if (ex_dwe) log_q.push_back('{1'b0, ex_daddr, ex_ddata});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Present one byte from a negedge; returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input int nb, input bit gap);
    for (int k = nb - 1; k >= 0; k--) begin
      send_byte(w[8*k +: 8]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic check_log(input int first, input int n, input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, 64'(log_q.size()), 64'(n));
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      chk({tag, "_kind"}, 64'(log_q[i].is_i), 64'(exp_tbl[first+i].is_i));
      chk({tag, "_addr"}, 64'(log_q[i].addr), 64'(exp_tbl[first+i].addr));
      chk({tag, "_data"}, log_q[i].data, exp_tbl[first+i].data);
    end
    log_q.delete();
  endtask

  task automatic go_run(input logic [15:0] mid_val, input logic [15:0] done_val,
                        input logic [15:0] exp, input int hold);
    int lowcnt = 0;
    send_byte(8'h47);
    while (!cpu_rst_n && lowcnt < 50) begin
      lowcnt++;
      @(negedge clk);
    end
    chk("go_rst_len", 64'(lowcnt), 64'd2);
    chk("run_in_ready", 64'(in_ready), 64'd0);
    chk("run_busy", 64'(busy), 64'd1);
    cpu_out_r = mid_val;
    repeat (2) @(negedge clk);
    cpu_out_r = 16'h0000;
    @(negedge clk);
    chk("run_no_res", 64'(res_valid), 64'd0);
    cpu_out_r = done_val;
    cpu_done  = 1'b1;
    @(negedge clk);
    cpu_done  = 1'b0;
    cpu_out_r = 16'h0000;
    chk("res_valid", 64'(res_valid), 64'd1);
    chk("res_data", 64'(res_data), 64'(exp));
    chk("rep_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("res_hold_valid", 64'(res_valid), 64'd1);
      chk("res_hold_data", 64'(res_data), 64'(exp));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_done_valid", 64'(res_valid), 64'd0);
    chk("res_done_busy", 64'(busy), 64'd0);
    chk("res_done_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    exp_tbl[0]  = '{1'b1, 7'h0, 64'h0001};
    exp_tbl[1]  = '{1'b1, 7'h1, 64'h0102};
    exp_tbl[2]  = '{1'b1, 7'h2, 64'h0204};
    exp_tbl[3]  = '{1'b1, 7'h3, 64'h0306};
    exp_tbl[4]  = '{1'b1, 7'h4, 64'h0408};
    exp_tbl[5]  = '{1'b1, 7'h5, 64'h050A};
    exp_tbl[6]  = '{1'b1, 7'h6, 64'h060C};
    exp_tbl[7]  = '{1'b1, 7'h7, 64'h070E};
    exp_tbl[8]  = '{1'b0, 7'h7E, 64'h0102030405060708};
    exp_tbl[9]  = '{1'b0, 7'h7F, 64'h1112131415161718};
    exp_tbl[10] = '{1'b0, 7'h00, 64'hA1B2C3D4E5F60789};
    exp_tbl[11] = '{1'b0, 7'h20, 64'hDEADBEEF00C0FFEE};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    cpu_out_r = 16'h0000; cpu_done = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_we", 64'({ex_iwe, ex_dwe}), 64'd0);

    // Instruction load, back-to-back bytes
    send_byte(8'h49);
    chk("iload_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 8; k++) send_word(exp_tbl[k].data, 2, 1'b0);
    check_log(0, 8, "iload");
    chk("iload_idle", 64'(busy), 64'd0);

    // Data load with address wrap; header bit7 set must be ignored
    send_byte(8'h44); send_byte(8'hFE); send_byte(8'h03);
    for (int k = 8; k < 11; k++) send_word(exp_tbl[k].data, 8, 1'b0);
    check_log(8, 3, "dload");

    // Same load with host valid toggling every byte
    send_byte(8'h44); @(negedge clk); send_byte(8'h7E); @(negedge clk);
    send_byte(8'h03); @(negedge clk);
    for (int k = 8; k < 11; k++) send_word(exp_tbl[k].data, 8, 1'b1);
    check_log(8, 3, "dload_gap");

    // Zero count header returns to IDLE without writing
    send_byte(8'h44); send_byte(8'h10); send_byte(8'h00);
    chk("dzero_busy", 64'(busy), 64'd0);
    check_log(0, 0, "dzero");

    // Unknown command sets err; next valid command clears it
    send_byte(8'h55);
    chk("bad_err", 64'(err), 64'd1);
    chk("bad_busy", 64'(busy), 64'd0);
    send_byte(8'h49);
    chk("bad_err_clr", 64'(err), 64'd0);
    for (int k = 0; k < 8; k++) send_word(exp_tbl[k].data, 2, 1'b0);
    check_log(0, 8, "iload2");

    // Asynchronous reset in the middle of a data word
    send_byte(8'h44); send_byte(8'h00); send_byte(8'h02);
    for (int k = 0; k < 5; k++) send_byte(8'hC0 + 8'(k));
    chk("abort_busy_pre", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("abort_async_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check_log(0, 0, "abort");
    send_byte(8'h44); send_byte(8'hA0); send_byte(8'h01);
    send_word(exp_tbl[11].data, 8, 1'b0);
    check_log(11, 1, "after_abort");

    // Run sequences: label held in shadow, label on done cycle, label zero
    go_run(16'h0007, 16'h0000, 16'h0007, 5);
    go_run(16'h0003, 16'h0009, 16'h0009, 1);
    go_run(16'h0000, 16'h0000, 16'h0000, 0);

`ifdef LOADER_TIMEOUT_EN
    begin
      int n = 0;
      send_byte(8'h47);
      while (!cpu_rst_n && n < 50) begin @(negedge clk); n++; end
      n = 0;
      while (!res_valid && n < 300) begin @(negedge clk); n++; end
      chk("to_cycles", 64'(n), 64'd100);
      chk("to_err", 64'(err), 64'd1);
      chk("to_data", 64'(res_data), 64'hFFFF);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("to_idle", 64'(busy), 64'd0);
    end
`endif

    chk("no_dual_write", 64'(both_hi), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
